uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte sources: port 0, the loader echo path, and port 1, the brainfuck core output. Each port gets its own small FIFO. A round-robin scheduler drains the FIFOs into the UART using the existing `start_transmit` pulse / `tx_ready` level handshake. The block sits in the `sysClk` domain, between the requesters and the clock-domain-crossing cells in front of the UART.

---
 rtl/uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between two byte sources (port 0: loader echo,
// port 1: core output). Each port owns a small circular FIFO; a round-robin
// scheduler pops the FIFOs into the UART with a start_transmit pulse and
// follows the tx_ready level through a three-state handshake FSM.
// Optional build macro: UART_TX_ARB_STATS_EN adds saturating per-port drop
// counters (drop0/drop1) for writes lost on a full FIFO.

module uart_tx_arbiter #(
    parameter int FIFO_LOG2    = 3,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       flush,
    input  logic       wr0,
    input  logic [7:0] data0,
    output logic       full0,
    input  logic       wr1,
    input  logic [7:0] data1,
    output logic       full1,
    input  logic       tx_ready,
    output logic       start_transmit,
    output logic [7:0] data_tx,
    output logic       busy
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [7:0] drop0,
    output logic [7:0] drop1
`endif
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [FIFO_LOG2:0]   CNT_ZERO   = (FIFO_LOG2 + 1)'(0);
    localparam logic [FIFO_LOG2:0]   CNT_FULL   = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0] PTR_ZERO   = FIFO_LOG2'(0);
    localparam logic [TW-1:0]        TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_IDLE = 2'd2
    } state_e;

    // FIFO storage and bookkeeping, index 0 = port 0, index 1 = port 1
    logic [7:0]           mem_q    [2][DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q [2];
    logic [FIFO_LOG2-1:0] wr_ptr_d [2];
    logic [FIFO_LOG2-1:0] rd_ptr_q [2];
    logic [FIFO_LOG2-1:0] rd_ptr_d [2];
    logic [FIFO_LOG2:0]   cnt_q    [2];
    logic [FIFO_LOG2:0]   cnt_d    [2];
    logic [7:0]           wdata_s  [2];
    logic [1:0]           wr_s;
    logic [1:0]           push_s;
    logic [1:0]           pop_s;
    logic [1:0]           ne_s;
    logic [1:0]           full_q;
    logic [1:0]           full_d;

    // Scheduler / FSM state
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          start_q;
    logic          start_d;
    logic [7:0]    data_tx_q;
    logic [7:0]    data_tx_d;
    logic          last_q;
    logic          last_d;
    logic          busy_q;
    logic          busy_d;
    logic          grant_s;
    logic          sel_s;

    // Grant decision: round robin between non-empty FIFOs while the UART is idle
    always_comb begin
        wr_s       = {wr1, wr0};
        wdata_s[0] = data0;
        wdata_s[1] = data1;
        ne_s[0]    = (cnt_q[0] != CNT_ZERO);
        ne_s[1]    = (cnt_q[1] != CNT_ZERO);
        // flush empties the FIFOs this edge, so nothing may be popped alongside it
        grant_s    = (state_q == ST_IDLE) && tx_ready && (ne_s != 2'b00) && !flush;
        if (ne_s == 2'b11) begin
            sel_s = ~last_q;
        end else if (ne_s[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // FIFO next state: push/pop per port, flush overrides everything
    always_comb begin
        pop_s  = 2'b00;
        push_s = 2'b00;
        full_d = 2'b00;
        for (int p = 0; p < 2; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            cnt_d[p]    = cnt_q[p];
            pop_s[p]    = grant_s && (sel_s == 1'(p));
            // a full FIFO still accepts a write when its head leaves the same cycle
            push_s[p]   = wr_s[p] && !flush && ((cnt_q[p] != CNT_FULL) || pop_s[p]);
            if (flush) begin
                wr_ptr_d[p] = PTR_ZERO;
                rd_ptr_d[p] = PTR_ZERO;
                cnt_d[p]    = CNT_ZERO;
            end else begin
                wr_ptr_d[p] = wr_ptr_q[p] + FIFO_LOG2'(push_s[p]);
                rd_ptr_d[p] = rd_ptr_q[p] + FIFO_LOG2'(pop_s[p]);
                cnt_d[p]    = cnt_q[p] + (FIFO_LOG2 + 1)'(push_s[p])
                                       - (FIFO_LOG2 + 1)'(pop_s[p]);
            end
            full_d[p] = (cnt_d[p] == CNT_FULL);
        end
    end

    // FSM next state: start pulse, wait for UART busy (with timeout), wait for idle
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        data_tx_d = data_tx_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d   = ST_WAIT_BUSY;
                    timer_d   = TIMER_ZERO;
                    start_d   = 1'b1;
                    data_tx_d = mem_q[sel_s][rd_ptr_q[sel_s]];
                    last_d    = sel_s;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    // UART never acknowledged; move on rather than deadlock
                    state_d = ST_WAIT_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (cnt_d[0] != CNT_ZERO) || (cnt_d[1] != CNT_ZERO) || (state_d != ST_IDLE);
    end

    // FIFO pointer, count and full-flag registers
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= PTR_ZERO;
                rd_ptr_q[p] <= PTR_ZERO;
                cnt_q[p]    <= CNT_ZERO;
            end
            full_q <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                cnt_q[p]    <= cnt_d[p];
            end
            full_q <= full_d;
        end
    end

    // FIFO storage write; contents beyond the count are never read, so no reset
    always_ff @(posedge sysClk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_q[p][wr_ptr_q[p]] <= wdata_s[p];
            end
        end
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= TIMER_ZERO;
            start_q   <= 1'b0;
            data_tx_q <= 8'h00;
            last_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            start_q   <= start_d;
            data_tx_q <= data_tx_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    assign full0          = full_q[0];
    assign full1          = full_q[1];
    assign start_transmit = start_q;
    assign data_tx        = data_tx_q;
    assign busy           = busy_q;

`ifdef UART_TX_ARB_STATS_EN
    logic [7:0] drop_q     [2];
    logic [7:0] drop_d     [2];
    logic [1:0] drop_evt_s;

    // Drop counters: a write that neither lands nor is cleared by flush is lost
    always_comb begin
        drop_evt_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            drop_evt_s[p] = wr_s[p] && !flush && !push_s[p];
            if (drop_evt_s[p] && (drop_q[p] != 8'hFF)) begin
                drop_d[p] = drop_q[p] + 8'd1;
            end else begin
                drop_d[p] = drop_q[p];
            end
        end
    end

    // Drop counter registers; flush intentionally leaves them alone
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            drop_q[0] <= 8'h00;
            drop_q[1] <= 8'h00;
        end else begin
            drop_q[0] <= drop_d[0];
            drop_q[1] <= drop_d[1];
        end
    end

    assign drop0 = drop_q[0];
    assign drop1 = drop_q[1];
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: latency, round robin, overflow,
// busy timeout, flush and asynchronous reset, with hand-computed expectations.

module tb_uart_tx_arbiter;

    logic       sysClk;
    logic       reset;
    logic       flush;
    logic       wr0;
    logic [7:0] data0;
    logic       full0;
    logic       wr1;
    logic [7:0] data1;
    logic       full1;
    logic       tx_ready;
    logic       start_transmit;
    logic [7:0] data_tx;
    logic       busy;
`ifdef UART_TX_ARB_STATS_EN
    logic [7:0] drop0;
    logic [7:0] drop1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arbiter dut (
        .sysClk         (sysClk),
        .reset          (reset),
        .flush          (flush),
        .wr0            (wr0),
        .data0          (data0),
        .full0          (full0),
        .wr1            (wr1),
        .data1          (data1),
        .full1          (full1),
        .tx_ready       (tx_ready),
        .start_transmit (start_transmit),
        .data_tx        (data_tx),
        .busy           (busy)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .drop0          (drop0),
        .drop1          (drop1)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    // Absolute time bound in case a step stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (start_transmit !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(start_transmit), 32'd1);
    endtask

    // One complete UART transfer: expect a start pulse carrying exp_byte
    task automatic xfer(input string tag, input logic [7:0] exp_byte);
        wait_start(tag);
        check({tag, "_data"}, 32'(data_tx), 32'(exp_byte));
        tx_ready = 1'b0;
        tick();
        check({tag, "_pulse"}, 32'(start_transmit), 32'd0);
        repeat (3) tick();
        tx_ready = 1'b1;
    endtask

    initial begin
        int n;
        int extra;

        reset    = 1'b1;
        flush    = 1'b0;
        wr0      = 1'b0;
        wr1      = 1'b0;
        data0    = 8'h00;
        data1    = 8'h00;
        tx_ready = 1'b1;

        // ---- reset values ----
        #2 reset = 1'b0;
        #1;
        check("rst_start", 32'(start_transmit), 32'd0);
        check("rst_data",  32'(data_tx),        32'h00);
        check("rst_full0", 32'(full0),          32'd0);
        check("rst_full1", 32'(full1),          32'd0);
        check("rst_busy",  32'(busy),           32'd0);
`ifdef UART_TX_ARB_STATS_EN
        check("rst_drop0", 32'(drop0), 32'd0);
`endif
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---- single byte on port 1, exact latency ----
        wr1   = 1'b1;
        data1 = 8'h41;
        tick();
        wr1 = 1'b0;
        check("t1_no_start_yet", 32'(start_transmit), 32'd0);
        check("t1_busy_queued",  32'(busy),           32'd1);
        tick();
        check("t1_start",        32'(start_transmit), 32'd1);
        check("t1_data",         32'(data_tx),        32'h41);
        tx_ready = 1'b0;
        tick();
        check("t1_pulse_one",    32'(start_transmit), 32'd0);
        check("t1_busy_wait",    32'(busy),           32'd1);
        tick();
        tx_ready = 1'b1;
        tick();
        check("t1_busy_done",    32'(busy),           32'd0);
        check("t1_data_hold",    32'(data_tx),        32'h41);

        // ---- round robin with both FIFOs preloaded ----
        tx_ready = 1'b0;
        wr0 = 1'b1; data0 = 8'h10;
        wr1 = 1'b1; data1 = 8'h20;
        tick();
        data0 = 8'h11;
        data1 = 8'h21;
        tick();
        wr0 = 1'b0;
        wr1 = 1'b0;
        check("rr_hold_no_start", 32'(start_transmit), 32'd0);
        tx_ready = 1'b1;
        xfer("rr0", 8'h10);
        xfer("rr1", 8'h20);
        xfer("rr2", 8'h11);
        xfer("rr3", 8'h21);
        tick();
        tick();
        check("rr_busy_done", 32'(busy), 32'd0);

        // ---- overflow: 9 writes into an 8-deep FIFO ----
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr0   = 1'b1;
            data0 = 8'h30 + 8'(i);
            tick();
            check($sformatf("ovf_fill%0d_full0", i), 32'(full0), (i >= 7) ? 32'd1 : 32'd0);
        end
        wr0 = 1'b0;
        check("ovf_full1", 32'(full1), 32'd0);
`ifdef UART_TX_ARB_STATS_EN
        check("ovf_drop0", 32'(drop0), 32'd1);
        check("ovf_drop1", 32'(drop1), 32'd0);
`endif
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xfer($sformatf("ovf%0d", i), 8'h30 + 8'(i));
            if (i == 0) begin
                check("ovf_full0_clear", 32'(full0), 32'd0);
            end
        end
        extra = 0;
        repeat (10) begin
            tick();
            if (start_transmit === 1'b1) extra++;
        end
        check("ovf_no_ninth", 32'(extra), 32'd0);
        check("ovf_busy_done", 32'(busy), 32'd0);

        // ---- busy timeout: tx_ready stuck high ----
        wr1   = 1'b1;
        data1 = 8'h55;
        tick();
        data1 = 8'h56;
        tick();
        wr1 = 1'b0;
        check("to_start0", 32'(start_transmit), 32'd1);
        check("to_data0",  32'(data_tx),        32'h55);
        n = 0;
        do begin
            tick();
            n++;
        end while (start_transmit !== 1'b1 && n < 200);
        check("to_interval", 32'(n),       32'd66);
        check("to_data1",    32'(data_tx), 32'h56);
        tx_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        tick();
        check("to_busy_done", 32'(busy), 32'd0);

        // ---- flush during WAIT_IDLE with 5 bytes queued ----
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr0   = 1'b1;
            data0 = 8'h60 + 8'(i);
            tick();
        end
        wr0 = 1'b0;
        tx_ready = 1'b1;
        wait_start("fl");
        check("fl_data", 32'(data_tx), 32'h60);
        tx_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy_inflight", 32'(busy),  32'd1);
        check("fl_full0",         32'(full0), 32'd0);
        tick();
        tick();
        tx_ready = 1'b1;
        tick();
        check("fl_busy_idle", 32'(busy), 32'd0);
        extra = 0;
        repeat (20) begin
            tick();
            if (start_transmit === 1'b1) extra++;
        end
        check("fl_no_more_starts", 32'(extra),   32'd0);
        check("fl_data_hold",      32'(data_tx), 32'h60);

        // ---- asynchronous reset in WAIT_BUSY ----
        wr0   = 1'b1;
        data0 = 8'h77;
        tick();
        data0 = 8'h78;
        tick();
        wr0 = 1'b0;
        check("ar_start_pre", 32'(start_transmit), 32'd1);
        check("ar_data_pre",  32'(data_tx),        32'h77);
        #2 reset = 1'b0;
        #1;
        check("ar_start", 32'(start_transmit), 32'd0);
        check("ar_data",  32'(data_tx),        32'h00);
        check("ar_busy",  32'(busy),           32'd0);
        check("ar_full0", 32'(full0),          32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("ar_busy_after", 32'(busy),           32'd0);
        check("ar_no_start",   32'(start_transmit), 32'd0);

        // last register restarts at 1: port 0 wins the first contested grant
        tx_ready = 1'b0;
        wr0 = 1'b1; data0 = 8'h81;
        wr1 = 1'b1; data1 = 8'h91;
        tick();
        wr0 = 1'b0;
        wr1 = 1'b0;
        tx_ready = 1'b1;
        xfer("ar_rr0", 8'h81);
        xfer("ar_rr1", 8'h91);
        tick();
        tick();
        check("ar_rr_busy_done", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
